alu_share_arbiter: RTL

- Sequences the shared 64-bit ALU (3-bit `cntrl` select into the per-bit 8:1 result mux) between two requesters, e.g. the main datapath and an address/branch helper unit.
- Arbitrates round-robin and registers operands so the ALU inputs stay stable for a full execute cycle.
- Captures the result and flags, then returns them through a valid/ready response channel tagged with the requester ID.

---
 rtl/alu_share_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Time-shares one combinational ALU between two requesters.
//                Round-robin arbitration picks one request at a time. Its
//                operands are held in registers so the ALU inputs stay
//                constant for a full execute cycle. The ALU result and flags
//                are captured and returned on a valid/ready response channel,
//                tagged with the ID of the requester.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     system clock, rising edge
//    reset                   asynchronous reset, active low
//    req{0,1}_valid/ready    request handshake, one per requester
//    req{0,1}_op/a/b         ALU op code and operands of each requester
//    alu_a/alu_b/alu_cntrl   registered operands and op select to the ALU
//    alu_result/alu_flags    combinational ALU outputs {N,Z,V,C}
//    resp_valid/ready        response handshake
//    resp_id/result/flags    captured response, tagged with requester ID
//    resp_err                op code was illegal (result/flags forced to 0)
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags,
    output logic             resp_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Op codes the ALU mux implements; 001 and 111 are not legal.
    localparam logic [2:0] C_OP_PASSB = 3'b000;
    localparam logic [2:0] C_OP_ADD   = 3'b010;
    localparam logic [2:0] C_OP_SUB   = 3'b011;
    localparam logic [2:0] C_OP_AND   = 3'b100;
    localparam logic [2:0] C_OP_OR    = 3'b101;
    localparam logic [2:0] C_OP_XOR   = 3'b110;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic             r_last_grant;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;

    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic [3:0]       r_resp_flags;
    logic             r_resp_err;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_op_legal;

    // ------------------------------------------------------------------
    // Round-robin grant. If only one requester is valid, it wins. If both
    // are valid, the one that was not granted last time wins. Exactly one
    // of the two grants can be high.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | r_last_grant);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    end

    always_comb begin
        w_op_legal = 1'b0;
        case (r_op)
            C_OP_PASSB, C_OP_ADD, C_OP_SUB,
            C_OP_AND, C_OP_OR, C_OP_XOR: w_op_legal = 1'b1;
            default:                     w_op_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next_state = S_EXEC;
            S_EXEC:                  w_next_state = S_RESP;
            S_RESP:  if (resp_ready) w_next_state = S_IDLE;
            default:                 w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Ready is also gated by reset, so that all outputs
    // read 0 as soon as reset is asserted, even while requesters are
    // still driving valid.
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_grant0 & reset;
                req1_ready = w_grant1 & reset;
                w_accept   = w_grant0 | w_grant1;
            end
            S_RESP: begin
                resp_valid = 1'b1;
            end
            default: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
                resp_valid = 1'b0;
                w_accept   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture. These registers only change on an accepted
    // request, so the ALU inputs stay at their last values in IDLE and
    // RESP and do not glitch between ops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_op         <= 3'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_last_grant <= w_grant1;
            r_id         <= w_grant1;
            r_op         <= w_grant1 ? req1_op : req0_op;
            r_a          <= w_grant1 ? req1_a  : req0_a;
            r_b          <= w_grant1 ? req1_b  : req0_b;
        end
    end

    // ------------------------------------------------------------------
    // Response capture at the end of the single EXEC cycle. For an
    // illegal op, whatever the ALU mux returns is discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_flags  <= 4'd0;
            r_resp_err    <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_resp_id <= r_id;
            if (w_op_legal) begin
                r_resp_result <= alu_result;
                r_resp_flags  <= alu_flags;
                r_resp_err    <= 1'b0;
            end else begin
                r_resp_result <= '0;
                r_resp_flags  <= 4'd0;
                r_resp_err    <= 1'b1;
            end
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_cntrl   = r_op;

    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_flags  = r_resp_flags;
    assign resp_err    = r_resp_err;

endmodule
`default_nettype wire
